// File: rtl/fp_round_if.sv
// Handshake bundle between the fpcvt convert block, the rounding stage and its consumer.
interface fp_round_if;
  logic       in_valid;
  logic       in_ready;
  logic       sign;
  logic [2:0] exponent;
  logic [3:0] significand;
  logic       round_bit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] fp_out;
  logic       saturated;

  modport master (
    output in_valid, sign, exponent, significand, round_bit, out_ready,
    input  in_ready, out_valid, fp_out, saturated
  );

  modport slave (
    input  in_valid, sign, exponent, significand, round_bit, out_ready,
    output in_ready, out_valid, fp_out, saturated
  );
endinterface

// File: rtl/fp_round_stage.sv
// Two-stage round-half-up / renormalise / saturate stage packing {sign, exp, sig}
// into an 8-bit float, with valid/ready flow control on both sides.
module fp_round_stage (
  input  logic        clk,
  input  logic        rst,
  fp_round_if.slave   io
);

  // Significand plus round bit, kept 5 bits wide so the carry-out is visible.
  function automatic logic [4:0] round_half_up(input logic [3:0] sig, input logic rb);
    return {1'b0, sig} + {4'b0000, rb};
  endfunction

  // Returns {saturated, sign, exp, sig}; a carry bumps the exponent, or clamps at exp 7.
  function automatic logic [8:0] pack_sat(input logic s, input logic [2:0] e,
                                          input logic [4:0] sum);
    if (!sum[4])
      return {1'b0, s, e, sum[3:0]};
    else if (e != 3'd7)
      return {1'b0, s, e + 3'd1, 4'b1000};
    else
      return {1'b1, s, 3'b111, 4'b1111};
  endfunction

  logic       vld_p1_q, vld_p1_d;
  logic       sign_p1_q, sign_p1_d;
  logic [2:0] exp_p1_q, exp_p1_d;
  logic [4:0] sum_p1_q, sum_p1_d;
  logic       vld_p2_q, vld_p2_d;
  logic [7:0] fp_p2_q, fp_p2_d;
  logic       sat_p2_q, sat_p2_d;

  logic       s2_free;
  logic       adv_p1;
  logic       in_xfer;
  logic       out_xfer;
  logic       in_ready_c;
  logic [8:0] packed_p1;

  always_comb begin
    s2_free    = !vld_p2_q || io.out_ready;
    adv_p1     = vld_p1_q && s2_free;
    in_ready_c = !vld_p1_q || s2_free;
    in_xfer    = io.in_valid && in_ready_c;
    out_xfer   = vld_p2_q && io.out_ready;
    packed_p1  = pack_sat(sign_p1_q, exp_p1_q, sum_p1_q);

    vld_p1_d  = vld_p1_q;
    sign_p1_d = sign_p1_q;
    exp_p1_d  = exp_p1_q;
    sum_p1_d  = sum_p1_q;
    vld_p2_d  = vld_p2_q;
    fp_p2_d   = fp_p2_q;
    sat_p2_d  = sat_p2_q;

    // Stage 1: capture operand and add the round bit.
    if (in_xfer) begin
      vld_p1_d  = 1'b1;
      sign_p1_d = io.sign;
      exp_p1_d  = io.exponent;
      sum_p1_d  = round_half_up(io.significand, io.round_bit);
    end else if (adv_p1) begin
      vld_p1_d  = 1'b0;
    end

    // Stage 2: renormalise / saturate and hold while the consumer stalls.
    if (adv_p1) begin
      vld_p2_d = 1'b1;
      fp_p2_d  = packed_p1[7:0];
      sat_p2_d = packed_p1[8];
    end else if (out_xfer) begin
      vld_p2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      sign_p1_q <= 1'b0;
      exp_p1_q  <= 3'd0;
      sum_p1_q  <= 5'd0;
      vld_p2_q  <= 1'b0;
      fp_p2_q   <= 8'h00;
      sat_p2_q  <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      sign_p1_q <= sign_p1_d;
      exp_p1_q  <= exp_p1_d;
      sum_p1_q  <= sum_p1_d;
      vld_p2_q  <= vld_p2_d;
      fp_p2_q   <= fp_p2_d;
      sat_p2_q  <= sat_p2_d;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = vld_p2_q;
  assign io.fp_out    = fp_p2_q;
  assign io.saturated = sat_p2_q;

endmodule
